// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone cycle/burst encodings and port FSM state type
package wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4 = 2'b01;
  localparam logic [1:0] BTE_WRAP8 = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;
  typedef enum logic {ST_IDLE, ST_BURST} port_state_e;
  function automatic int idx_bits(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/wb_ram_mp_port.sv
// wb_ram_mp_port: per-port handshake/burst FSM, ack/err generation and range check
module wb_ram_mp_port
  import wb_pkg::*;
#(
  parameter int IW = 14,
  parameter int DEPTH = 2 ** IW,
  parameter int AW = idx_bits(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cyc,
  input  logic          stb,
  input  logic [IW-1:0] idx,
  input  logic [2:0]    cti,
  input  logic [1:0]    bte,
  output logic          hit,
  output logic [AW-1:0] widx,
  output logic          ack,
  output logic          err
);
  port_state_e state, state_nx;
  logic req, in_range, ack_nx, err_nx;
  assign in_range = {1'b0, idx} < (IW + 1)'(DEPTH);
  assign req = cyc && stb && (state == ST_BURST || !(ack || err));
  assign hit = req && in_range;
  assign widx = AW'(idx);
  // next state and next handshake outputs
  always_comb begin
    state_nx = state;
    ack_nx = hit;
    err_nx = req && !in_range;
    state_nx = (state == ST_IDLE)
      ? ((req && cti == CTI_INCR && bte == BTE_LINEAR) ? ST_BURST : ST_IDLE)
      : ((!cyc || (req && cti == CTI_EOB)) ? ST_IDLE : ST_BURST);
  end
  // state and registered ack/err; reset drops any in-flight beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      ack <= ack_nx;
      err <= err_nx;
    end
  end
endmodule

// File: rtl/wb_ram_mp.sv
// wb_ram_mp: multi-port Wishbone RAM with byte lanes and lowest-port-wins write collisions
module wb_ram_mp
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int PORTS = 2,
  parameter int DEPTH = 2 ** (ADDR_WIDTH - $clog2(SELECT_WIDTH))
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PORTS*ADDR_WIDTH-1:0]    adr_i,
  input  logic [PORTS*DATA_WIDTH-1:0]    dat_i,
  output logic [PORTS*DATA_WIDTH-1:0]    dat_o,
  input  logic [PORTS-1:0]               we_i,
  input  logic [PORTS*SELECT_WIDTH-1:0]  sel_i,
  input  logic [PORTS-1:0]               stb_i,
  input  logic [PORTS-1:0]               cyc_i,
  input  logic [PORTS*3-1:0]             cti_i,
  input  logic [PORTS*2-1:0]             bte_i,
  output logic [PORTS-1:0]               ack_o,
  output logic [PORTS-1:0]               err_o
);
  localparam int LSB = $clog2(SELECT_WIDTH);
  localparam int IW = ADDR_WIDTH - LSB;
  localparam int AW = idx_bits(DEPTH);
  logic [PORTS-1:0] hit;
  logic [AW-1:0] widx [PORTS];
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [DATA_WIDTH-1:0] rd_q;
    wb_ram_mp_port #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) u_port (
      .clk  (clk),
      .rst_n(rst_n),
      .cyc  (cyc_i[p]),
      .stb  (stb_i[p]),
      .idx  (adr_i[p*ADDR_WIDTH+LSB +: IW]),
      .cti  (cti_i[p*3 +: 3]),
      .bte  (bte_i[p*2 +: 2]),
      .hit  (hit[p]),
      .widx (widx[p]),
      .ack  (ack_o[p]),
      .err  (err_o[p])
    );
    // read data: capture the pre-write word on every accepted in-range beat, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else if (hit[p]) rd_q <= mem[widx[p]];
    end
    assign dat_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    if (LSB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^adr_i[p*ADDR_WIDTH +: LSB];
    end
  end
  // byte-lane writes; ports are visited high to low so the lowest-numbered port lands last and wins
  always_ff @(posedge clk) begin
    for (int p = PORTS - 1; p >= 0; p--)
      for (int b = 0; b < SELECT_WIDTH; b++)
        if (hit[p] && we_i[p] && sel_i[p*SELECT_WIDTH+b])
          mem[widx[p]][b*8 +: 8] <= dat_i[p*DATA_WIDTH+b*8 +: 8];
  end
endmodule

// File: tb/tb_wb_ram_mp.sv
// tb_wb_ram_mp: directed table-driven and sequence checks for wb_ram_mp
module tb_wb_ram_mp;
  localparam int P = 2, DW = 32, AW = 16, SW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [P*AW-1:0] adr_i = '0;
  logic [P*DW-1:0] dat_i = '0, dat_o;
  logic [P-1:0] we_i = '0, stb_i = '0, cyc_i = '0, ack_o, err_o;
  logic [P*SW-1:0] sel_i = '0;
  logic [P*3-1:0] cti_i = '0;
  logic [P*2-1:0] bte_i = '0;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    string name;
    int p;
    logic we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0] sel;
    logic [2:0] cti;
    logic [1:0] bte;
    logic ack;
    logic err;
    logic chk;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  wb_ram_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .PORTS(P), .DEPTH(100)) dut (
    .clk(clk), .rst_n(rst_n), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .we_i(we_i),
    .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .cti_i(cti_i), .bte_i(bte_i),
    .ack_o(ack_o), .err_o(err_o)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int p, input logic we, input logic [15:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    cyc_i[p] = 1'b1;
    stb_i[p] = 1'b1;
    we_i[p] = we;
    adr_i[p*AW +: AW] = adr;
    dat_i[p*DW +: DW] = dat;
    sel_i[p*SW +: SW] = sel;
    cti_i[p*3 +: 3] = cti;
    bte_i[p*2 +: 2] = bte;
  endtask
  task automatic idle(input int p);
    cyc_i[p] = 1'b0;
    stb_i[p] = 1'b0;
    we_i[p] = 1'b0;
    cti_i[p*3 +: 3] = 3'b000;
    bte_i[p*2 +: 2] = 2'b00;
  endtask
  task automatic beat(input int p, input logic [15:0] adr, input logic [2:0] cti);
    set_req(p, 1'b0, adr, 32'h0, 4'h0, cti, 2'b00);
  endtask
  task automatic run_vec(input vec_t v);
    set_req(v.p, v.we, v.adr, v.dat, v.sel, v.cti, v.bte);
    tick;
    check({v.name, "_ack"}, 64'(ack_o[v.p]), 64'(v.ack));
    check({v.name, "_err"}, 64'(err_o[v.p]), 64'(v.err));
    if (v.chk) check({v.name, "_dat"}, 64'(dat_o[v.p*DW +: DW]), 64'(v.rd));
    tick;
    check({v.name, "_gap"}, 64'(ack_o[v.p] | err_o[v.p]), 64'h0);
    idle(v.p);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick;
    tick;
    check("rst_ack", 64'(ack_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_dat", dat_o, 64'h0);
    rst_n = 1'b1;
    tick;
    tbl.push_back('{"w10",     0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{"r10",     0, 1'b0, 16'h0010, 32'h0,        4'h0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{"r13",     0, 1'b0, 16'h0013, 32'h0,        4'h0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{"w14",     1, 1'b1, 16'h0014, 32'h01020304, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{"w14part", 1, 1'b1, 16'h0014, 32'hAABBCCDD, 4'h5, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'h01020304});
    tbl.push_back('{"r16",     1, 1'b0, 16'h0016, 32'h0,        4'h0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'h01BB03DD});
    tbl.push_back('{"w_oor",   0, 1'b1, 16'h0190, 32'h12345678, 4'hF, 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{"w99",     0, 1'b1, 16'h018C, 32'hCAFEF00D, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{"r99",     0, 1'b0, 16'h018C, 32'h0,        4'h0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D});
    tbl.push_back('{"r_oor",   0, 1'b0, 16'h0190, 32'h0,        4'h0, 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D});
    tbl.push_back('{"w0",      1, 1'b1, 16'h0000, 32'h000000A0, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{"w4",      1, 1'b1, 16'h0004, 32'h000000A1, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{"w8",      1, 1'b1, 16'h0008, 32'h000000A2, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{"wc",      1, 1'b1, 16'h000C, 32'h000000A3, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{"w98",     1, 1'b1, 16'h0188, 32'h00000B98, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{"r8_wrap", 1, 1'b0, 16'h0008, 32'h0,        4'h0, 3'b010, 2'b01, 1'b1, 1'b0, 1'b1, 32'h000000A2});
    tbl.push_back('{"w30z",    0, 1'b1, 16'h0030, 32'h0,        4'hF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0});
    foreach (tbl[i]) run_vec(tbl[i]);
    set_req(0, 1'b1, 16'h0020, 32'h11111111, 4'h3, 3'b000, 2'b00);
    set_req(1, 1'b1, 16'h0020, 32'h22222222, 4'hF, 3'b000, 2'b00);
    tick;
    check("coll_ack", 64'(ack_o), 64'h3);
    check("coll_err", 64'(err_o), 64'h0);
    idle(0);
    idle(1);
    tick;
    run_vec('{"coll_rd", 0, 1'b0, 16'h0020, 32'h0, 4'h0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'h22221111});
    set_req(0, 1'b1, 16'h0030, 32'h00000055, 4'hF, 3'b000, 2'b00);
    beat(1, 16'h0030, 3'b000);
    tick;
    check("rw_ack", 64'(ack_o), 64'h3);
    check("rw_old", 64'(dat_o[DW +: DW]), 64'h0);
    idle(0);
    idle(1);
    tick;
    run_vec('{"rw_new", 1, 1'b0, 16'h0030, 32'h0, 4'h0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'h00000055});
    for (int i = 0; i < 4; i++) begin
      beat(1, 16'(i * 4), i == 3 ? 3'b111 : 3'b010);
      tick;
      check($sformatf("burst_ack%0d", i), 64'(ack_o[1]), 64'h1);
      check($sformatf("burst_dat%0d", i), 64'(dat_o[DW +: DW]), 64'(32'hA0 + i));
    end
    tick;
    check("burst_end", 64'(ack_o[1]), 64'h0);
    check("burst_hold", 64'(dat_o[DW +: DW]), 64'hA3);
    idle(1);
    tick;
    for (int i = 0; i < 4; i++) begin
      beat(0, 16'(16'h0188 + i * 4), i == 3 ? 3'b111 : 3'b010);
      tick;
      check($sformatf("oor_ack%0d", i), 64'(ack_o[0]), i < 2 ? 64'h1 : 64'h0);
      check($sformatf("oor_err%0d", i), 64'(err_o[0]), i < 2 ? 64'h0 : 64'h1);
      check($sformatf("oor_dat%0d", i), 64'(dat_o[0 +: DW]), i == 0 ? 64'hB98 : 64'hCAFEF00D);
    end
    tick;
    check("oor_end", 64'(ack_o[0] | err_o[0]), 64'h0);
    idle(0);
    tick;
    beat(1, 16'h0000, 3'b010);
    tick;
    check("drop_ack0", 64'(ack_o[1]), 64'h1);
    beat(1, 16'h0004, 3'b010);
    tick;
    check("drop_ack1", 64'(ack_o[1]), 64'h1);
    cyc_i[1] = 1'b0;
    tick;
    check("drop_end", 64'(ack_o[1]), 64'h0);
    idle(1);
    run_vec('{"drop_rd", 1, 1'b0, 16'h0008, 32'h0, 4'h0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'h000000A2});
    beat(0, 16'h0000, 3'b010);
    tick;
    check("rstb_ack0", 64'(ack_o[0]), 64'h1);
    beat(0, 16'h0004, 3'b010);
    rst_n = 1'b0;
    #1;
    check("rstb_ack", 64'(ack_o), 64'h0);
    check("rstb_err", 64'(err_o), 64'h0);
    check("rstb_dat", dat_o, 64'h0);
    tick;
    check("rstb_hold", 64'(ack_o | err_o), 64'h0);
    idle(0);
    rst_n = 1'b1;
    tick;
    run_vec('{"post_rst", 0, 1'b0, 16'h0008, 32'h0, 4'h0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'h000000A2});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
